// File: rtl/maze_store.sv
// maze_store: cell-code grid shared between a loader, a maze solver and a
// readback stream. The grid is loaded row-major, then the solver reads wall
// flags and marks cells visited, then the final grid is streamed out.
module maze_store #(
    parameter int maze_width = 6,
    parameter int cell_width = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic                    load_valid,
    input  logic [cell_width-1:0]   load_data,
    output logic                    load_ready,
    output logic                    load_done,
    input  logic [maze_width-1:0]   row,
    input  logic [maze_width-1:0]   col,
    input  logic                    maze_oe,
    input  logic                    maze_we,
    output logic                    maze_in,
    input  logic                    done,
    output logic                    dump_valid,
    output logic [cell_width-1:0]   dump_data,
    input  logic                    dump_ready,
    output logic [2*maze_width:0]   visit_count
);

    localparam int AW    = 2 * maze_width;
    localparam int CELLS = 1 << AW;

    localparam logic [AW-1:0]         ADDR_FIRST = '0;
    localparam logic [AW-1:0]         ADDR_LAST  = '1;
    localparam logic [AW:0]           VISIT_MAX  = {1'b1, {AW{1'b0}}};
    localparam logic [cell_width-1:0] CODE_FREE  = cell_width'(0);
    localparam logic [cell_width-1:0] CODE_WALL  = cell_width'(1);
    localparam logic [cell_width-1:0] CODE_VIS   = cell_width'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [cell_width-1:0] r_grid [0:CELLS-1];
    logic [AW-1:0]         r_load_addr;
    logic [AW-1:0]         r_dump_addr;
    logic                  r_load_done;
    logic                  r_maze_in;
    logic                  r_dump_valid;
    logic [cell_width-1:0] r_dump_data;
    logic [AW:0]           r_visit;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_run;
    logic                  w_mark;
    logic                  w_count;
    logic                  w_xfer;
    logic                  w_enter_dump;
    logic [AW-1:0]         w_cell_addr;
    logic [AW-1:0]         w_dump_next;
    logic [cell_width-1:0] w_cell;

    assign w_cell_addr  = {row, col};
    assign w_cell       = r_grid[w_cell_addr];
    assign w_run        = (r_state == S_RUN);
    assign w_start      = load_start && (r_state != S_DUMP);
    // A restart takes priority over a cell offered in the same cycle.
    assign w_accept     = load_ready && load_valid && !load_start;
    assign w_mark       = w_run && maze_we && (w_cell != CODE_WALL);
    assign w_count      = w_run && maze_we && (w_cell == CODE_FREE) && (r_visit != VISIT_MAX);
    assign w_xfer       = r_dump_valid && dump_ready;
    assign w_enter_dump = w_run && !load_start && done;
    assign w_dump_next  = r_dump_addr + 1'b1;

    assign load_done   = r_load_done;
    assign maze_in     = r_maze_in;
    assign dump_valid  = r_dump_valid;
    assign dump_data   = r_dump_data;
    assign visit_count = r_visit;

    // Next-state decode and the load handshake.
    always_comb begin
        w_next     = r_state;
        load_ready = 1'b0;
        case (r_state)
            S_IDLE: if (load_start) w_next = S_LOAD;
            S_LOAD: begin
                load_ready = 1'b1;
                if (load_start)
                    w_next = S_LOAD;
                else if (load_valid && (r_load_addr == ADDR_LAST))
                    w_next = S_RUN;
            end
            S_RUN: begin
                if (load_start)
                    w_next = S_LOAD;
                else if (done)
                    w_next = S_DUMP;
            end
            S_DUMP: if (w_xfer && (r_dump_addr == ADDR_LAST)) w_next = S_FIN;
            S_FIN:  if (load_start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Grid storage: loader writes in LOAD, solver marks non-wall cells in RUN.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_grid[r_load_addr] <= load_data;
        else if (w_mark)
            r_grid[w_cell_addr] <= CODE_VIS;
    end

    // Load address, status flags, solver read port, visit counter and dump stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_addr  <= '0;
            r_dump_addr  <= '0;
            r_load_done  <= 1'b0;
            r_maze_in    <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_data  <= '0;
            r_visit      <= '0;
        end else begin
            // Also high for the first LOAD cycle after a restart from FIN.
            r_load_done <= (w_next == S_RUN) || ((r_state == S_FIN) && load_start);

            if (w_start)
                r_load_addr <= '0;
            else if (w_accept)
                r_load_addr <= r_load_addr + 1'b1;

            if (w_start)
                r_visit <= '0;
            else if (w_count)
                r_visit <= r_visit + 1'b1;

            // The read sees the pre-write cell, so oe+we on one cell returns old contents.
            if (w_run && maze_oe)
                r_maze_in <= (w_cell == CODE_WALL);

            // r_dump_addr indexes the cell currently presented; the next one is fetched on accept.
            if (w_enter_dump) begin
                r_dump_addr  <= '0;
                r_dump_data  <= r_grid[ADDR_FIRST];
                r_dump_valid <= 1'b1;
            end else if (w_xfer) begin
                if (r_dump_addr == ADDR_LAST) begin
                    r_dump_valid <= 1'b0;
                end else begin
                    r_dump_addr <= w_dump_next;
                    r_dump_data <= r_grid[w_dump_next];
                end
            end
        end
    end

endmodule
